// File: rtl/subtractor16_seq.sv
// Multi-cycle 16-bit unsigned subtractor: z = x - y through one reused 4-bit slice, LSB nibble first.
// Optional signed-overflow output ovf is built when SUB16_OVF_EN is defined.
module subtractor16_seq #(
    parameter int NIB_W = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         start,
    output logic [W-1:0] z,
    output logic         borrow,
    output logic         busy,
    output logic         done
`ifdef SUB16_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int NIBS = W / NIB_W;
    localparam logic [1:0] LAST_IDX = 2'(NIBS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [W-1:0]     x_r, y_r, shadow, shadow_nx;
    logic [1:0]       idx;
    logic             carry;
    logic             accept;
    logic [NIB_W-1:0] x_nib, y_nib;
    logic [NIB_W:0]   sum;

    // Handshake: a request is taken on any rising edge where start=1 and busy=0
    // (IDLE or DONE); start while busy is simply ignored.
    assign accept = start && !busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (idx == LAST_IDX) state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // One slice: x + ~y + carry, borrow of the whole word is the inverted final carry.
    always_comb begin
        x_nib     = x_r[idx*NIB_W +: NIB_W];
        y_nib     = y_r[idx*NIB_W +: NIB_W];
        sum       = {1'b0, x_nib} + {1'b0, ~y_nib} + {{NIB_W{1'b0}}, carry};
        shadow_nx = shadow;
        shadow_nx[idx*NIB_W +: NIB_W] = sum[NIB_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r    <= '0;
            y_r    <= '0;
            shadow <= '0;
            idx    <= '0;
            carry  <= 1'b1;
            z      <= '0;
            borrow <= 1'b0;
`ifdef SUB16_OVF_EN
            ovf    <= 1'b0;
`endif
        end else if (accept) begin
            x_r    <= x;
            y_r    <= y;
            shadow <= '0;
            idx    <= '0;
            carry  <= 1'b1;
        end else if (state == RUN) begin
            shadow <= shadow_nx;
            carry  <= sum[NIB_W];
            idx    <= idx + 2'd1;
            if (idx == LAST_IDX) begin
                z      <= shadow_nx;
                borrow <= ~sum[NIB_W];
`ifdef SUB16_OVF_EN
                ovf    <= (x_r[W-1] != y_r[W-1]) && (sum[NIB_W-1] != x_r[W-1]);
`endif
            end
        end
    end

endmodule
